// File: rtl/muldiv_pkg.sv
// Shared encodings for the mult/div sequencer.
//   OP_*    : decoder op codes; the op value is also the unit index for unit_start/unit_ready.
//   state_e : sequencer states.
//   DIV0_LO : LO value written when a divide by zero is short-circuited.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_WRITE = 2'b11
  } state_e;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  // Divide ops have op[1] set.
  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// Cycle counter guarding the WAIT state of the mult/div sequencer.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : synchronous clear (wins over enable)
//   en_i         : count one per cycle
//   expired_o    : count has reached TIMEOUT-1
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_sched.sv
// Sequencer for the four multi-cycle arithmetic units and the HI/LO register.
// Takes one request from the decoder, latches operands, pulses the selected unit's start,
// waits for its ready, then writes HI/LO for one cycle. Divide by zero is answered locally
// (HI = dividend, LO = all ones); a unit that never answers is aborted after TIMEOUT cycles.
// Ports:
//   clk_i, rst_i               : clock, asynchronous active-high reset
//   start_i, op_i              : request and op (00 mult, 01 multu, 10 div, 11 divu)
//   rs_data_i, rt_data_i       : operands a / b
//   unit_a_o, unit_b_o         : latched operands to all units
//   unit_start_o               : one-hot start pulse (bit = op)
//   unit_sel_o                 : latched op, selects the external hi/lo result mux
//   unit_ready_i               : per-unit done flags
//   unit_hi_i, unit_lo_i       : muxed result words
//   unit_abort_o               : one-cycle unit reset on timeout
//   stall_o                    : hold PC (combinational)
//   hilo_we_o, hilo_hi_o/_lo_o : HI/LO write strobe and data
//   div0_o, timeout_err_o      : one-cycle event flags
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [31:0] unit_a_o,
  output logic [31:0] unit_b_o,
  output logic [3:0]  unit_start_o,
  output logic [1:0]  unit_sel_o,
  input  logic [3:0]  unit_ready_i,
  input  logic [31:0] unit_hi_i,
  input  logic [31:0] unit_lo_i,
  output logic        unit_abort_o,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [31:0] hilo_hi_o,
  output logic [31:0] hilo_lo_o,
  output logic        div0_o,
  output logic        timeout_err_o
);

  state_e      state_q;
  logic [31:0] unit_a_q, unit_b_q, hilo_hi_q, hilo_lo_q;
  logic [1:0]  unit_sel_q;
  logic [3:0]  unit_start_q;
  logic        hilo_we_q, div0_q, unit_abort_q, timeout_err_q;
  logic        accept, wd_expired;

  assign accept = (state_q == S_IDLE) && start_i;

  muldiv_watchdog #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (accept),
    .en_i     (state_q == S_WAIT),
    .expired_o(wd_expired)
  );

  // Flags are registered on the transition into the state they belong to, so each one is
  // high for exactly the cycle spent in that state (or the cycle after a timeout).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      unit_a_q      <= '0;
      unit_b_q      <= '0;
      unit_sel_q    <= '0;
      hilo_hi_q     <= '0;
      hilo_lo_q     <= '0;
      unit_start_q  <= '0;
      hilo_we_q     <= 1'b0;
      div0_q        <= 1'b0;
      unit_abort_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      unit_start_q  <= '0;
      hilo_we_q     <= 1'b0;
      div0_q        <= 1'b0;
      unit_abort_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            unit_a_q   <= rs_data_i;
            unit_sel_q <= op_i;
            if (is_div(op_i) && (rt_data_i == '0)) begin
              hilo_hi_q <= rs_data_i;
              hilo_lo_q <= DIV0_LO;
              hilo_we_q <= 1'b1;
              div0_q    <= 1'b1;
              state_q   <= S_WRITE;
            end else begin
              unit_b_q     <= rt_data_i;
              unit_start_q <= 4'(1) << op_i;
              state_q      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          // Ready has priority over the timeout on the final cycle.
          if (unit_ready_i[unit_sel_q]) begin
            hilo_hi_q <= unit_hi_i;
            hilo_lo_q <= unit_lo_i;
            hilo_we_q <= 1'b1;
            state_q   <= S_WRITE;
          end else if (wd_expired) begin
            unit_abort_q  <= 1'b1;
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        S_WRITE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Low in WRITE so the PC advances and the next instruction sees the new HI/LO.
  assign stall_o = accept || (state_q == S_ISSUE) || (state_q == S_WAIT);

  assign unit_a_o      = unit_a_q;
  assign unit_b_o      = unit_b_q;
  assign unit_sel_o    = unit_sel_q;
  assign unit_start_o  = unit_start_q;
  assign unit_abort_o  = unit_abort_q;
  assign hilo_we_o     = hilo_we_q;
  assign hilo_hi_o     = hilo_hi_q;
  assign hilo_lo_o     = hilo_lo_q;
  assign div0_o        = div0_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: a per-transaction unit model answers with a fixed latency
// and per-cycle observations are summarised and compared against hand-computed values.
module tb_muldiv_sched;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] rs_data_i = '0, rt_data_i = '0;
  logic [31:0] unit_a_o, unit_b_o;
  logic [3:0]  unit_start_o;
  logic [1:0]  unit_sel_o;
  logic [3:0]  unit_ready_i = '0;
  logic [31:0] unit_hi_i = '0, unit_lo_i = '0;
  logic        unit_abort_o, stall_o, hilo_we_o, div0_o, timeout_err_o;
  logic [31:0] hilo_hi_o, hilo_lo_o;

  muldiv_sched #(
    .TIMEOUT(64),
    .CNT_W  (7)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .op_i         (op_i),
    .rs_data_i    (rs_data_i),
    .rt_data_i    (rt_data_i),
    .unit_a_o     (unit_a_o),
    .unit_b_o     (unit_b_o),
    .unit_start_o (unit_start_o),
    .unit_sel_o   (unit_sel_o),
    .unit_ready_i (unit_ready_i),
    .unit_hi_i    (unit_hi_i),
    .unit_lo_i    (unit_lo_i),
    .unit_abort_o (unit_abort_o),
    .stall_o      (stall_o),
    .hilo_we_o    (hilo_we_o),
    .hilo_hi_o    (hilo_hi_o),
    .hilo_lo_o    (hilo_lo_o),
    .div0_o       (div0_o),
    .timeout_err_o(timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-transaction observations.
  int          n_stall, n_start, n_we, n_div0, n_abort, n_to, we_stall, latch_bad;
  logic [3:0]  start_val;
  logic [31:0] we_hi, we_lo;
  logic [1:0]  we_sel;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request at the current cycle and observe ncyc cycles.
  // lat = WAIT cycle on which the selected unit raises ready (0 = never).
  // noise drives the other units' ready bits; restart re-asserts start with other operands
  // from the first WAIT cycle through the WRITE cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] rhi, input logic [31:0] rlo,
                        input bit restart, input bit noise, input int ncyc);
    logic [3:0] oh;
    int         wcnt;
    bit         started_now;
    oh = 4'b0001 << op;
    n_stall = 0; n_start = 0; n_we = 0; n_div0 = 0; n_abort = 0; n_to = 0;
    we_stall = 0; latch_bad = 0; start_val = '0; we_hi = '0; we_lo = '0; we_sel = '0;
    wcnt = 0;
    op_i = op; rs_data_i = a; rt_data_i = b; start_i = 1'b1;
    unit_hi_i = rhi; unit_lo_i = rlo;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (lat > 0 && wcnt == lat) unit_ready_i = oh;
      else if (noise)             unit_ready_i = ~oh;
      else                        unit_ready_i = '0;
      #1;
      if (stall_o) n_stall++;
      if (unit_start_o != '0) begin n_start++; start_val = unit_start_o; end
      if (hilo_we_o) begin
        n_we++; we_hi = hilo_hi_o; we_lo = hilo_lo_o; we_sel = unit_sel_o;
        if (stall_o) we_stall++;
      end
      if (div0_o) n_div0++;
      if (unit_abort_o) n_abort++;
      if (timeout_err_o) n_to++;
      if (cyc > 0 && (unit_a_o != a || unit_b_o != b)) latch_bad++;
      started_now = (unit_start_o != '0);
      @(posedge clk_i); #1;
      if (started_now) wcnt = 1;
      else if (wcnt > 0) wcnt++;
      if (restart && wcnt >= 1 && wcnt <= lat + 1) begin
        start_i = 1'b1; rs_data_i = ~a; rt_data_i = b + 32'd7; op_i = ~op;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    unit_ready_i = '0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #2;
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_unit_a", unit_a_o, 0);
    check_eq("rst_hilo_hi", hilo_hi_o, 0);
    check_eq("rst_flags", {unit_start_o, unit_abort_o, hilo_we_o, div0_o, timeout_err_o}, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // 1. mult -3 * 5, ready on 4th WAIT cycle, other units' ready bits noisy
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 4, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1, 10);
    check_eq("mult_nstart", n_start, 1);
    check_eq("mult_startval", start_val, 4'b0001);
    check_eq("mult_stall", n_stall, 6);
    check_eq("mult_nwe", n_we, 1);
    check_eq("mult_hilo", {we_hi, we_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
    check_eq("mult_we_stall", we_stall, 0);
    check_eq("mult_div0", n_div0, 0);

    // 2. divu 100 / 0
    run_op(2'b11, 32'd100, 32'd0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 4);
    check_eq("div0_nstart", n_start, 0);
    check_eq("div0_stall", n_stall, 1);
    check_eq("div0_nwe", n_we, 1);
    check_eq("div0_hilo", {we_hi, we_lo}, {32'd100, 32'hFFFF_FFFF});
    check_eq("div0_flag", n_div0, 1);
    check_eq("div0_sel", unit_sel_o, 2'b11);

    // 3. div, unit never ready
    run_op(2'b10, 32'd50, 32'd3, 0, 32'h0, 32'h0, 1'b0, 1'b0, 72);
    check_eq("to_startval", start_val, 4'b0100);
    check_eq("to_stall", n_stall, 66);
    check_eq("to_abort", n_abort, 1);
    check_eq("to_err", n_to, 1);
    check_eq("to_nwe", n_we, 0);
    check_eq("to_idle_stall", stall_o, 0);

    // 4. multu with start re-asserted during WAIT and WRITE
    run_op(2'b01, 32'h1234_5678, 32'h10, 3, 32'h1, 32'h2345_6780, 1'b1, 1'b0, 10);
    check_eq("re_nstart", n_start, 1);
    check_eq("re_nwe", n_we, 1);
    check_eq("re_latch", latch_bad, 0);
    check_eq("re_ab", {unit_a_o, unit_b_o}, {32'h1234_5678, 32'h10});
    check_eq("re_stall", n_stall, 5);
    check_eq("re_hilo", {we_hi, we_lo}, {32'h1, 32'h2345_6780});

    // 5. async reset mid-WAIT
    run_op(2'b01, 32'hAAAA_0001, 32'h3, 0, 32'h5, 32'h6, 1'b0, 1'b0, 5);
    check_eq("mid_stall_pre", stall_o, 1);
    #3 rst_i = 1'b1;
    #1;
    check_eq("mid_stall", stall_o, 0);
    check_eq("mid_regs", {unit_a_o, unit_b_o, unit_sel_o}, 0);
    check_eq("mid_flags", {unit_start_o, unit_abort_o, hilo_we_o, div0_o, timeout_err_o}, 0);
    #2 rst_i = 1'b0;
    unit_ready_i = 4'hF;
    n_we = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (hilo_we_o || stall_o) n_we++;
    end
    unit_ready_i = '0;
    check_eq("mid_late_ready", n_we, 0);
    check_eq("mid_hilo", {hilo_hi_o, hilo_lo_o}, 0);

    // 6. back-to-back div (ready at 3) then mult (ready at 2)
    run_op(2'b10, 32'd100, 32'd7, 3, 32'd2, 32'd14, 1'b0, 1'b0, 6);
    check_eq("b2b_div_nwe", n_we, 1);
    check_eq("b2b_div_sel", we_sel, 2'b10);
    check_eq("b2b_div_hilo", {we_hi, we_lo}, {32'd2, 32'd14});
    run_op(2'b00, 32'd6, 32'd7, 2, 32'd0, 32'd42, 1'b0, 1'b0, 6);
    check_eq("b2b_mul_start", start_val, 4'b0001);
    check_eq("b2b_mul_nwe", n_we, 1);
    check_eq("b2b_mul_sel", we_sel, 2'b00);
    check_eq("b2b_mul_hilo", {we_hi, we_lo}, {32'd0, 32'd42});

    // Ready on the final (64th) WAIT cycle beats the timeout
    run_op(2'b11, 32'd9, 32'd4, 64, 32'd1, 32'd2, 1'b0, 1'b0, 70);
    check_eq("edge_nwe", n_we, 1);
    check_eq("edge_to", n_to, 0);
    check_eq("edge_abort", n_abort, 0);
    check_eq("edge_stall", n_stall, 66);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
